// File: rtl/pipe_stage_buf.sv
// rtl/pipe_stage_buf.sv - valid/ready pipeline stage register with a 2-entry skid buffer
// Define PIPE_STAGE_BUF_STATS_EN to add saturating stall/bubble/flush counters.
module pipe_stage_buf #(
  parameter int DATA_W = 64,
  parameter int CTRL_W = 16,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  input  logic [CTRL_W-1:0] in_ctrl,
  output logic              in_ready,
  input  logic              flush,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  output logic [CTRL_W-1:0] out_ctrl,
  input  logic              out_ready,
  output logic [1:0]        occupancy
`ifdef PIPE_STAGE_BUF_STATS_EN
  ,
  output logic [CNT_W-1:0]  stall_cnt,
  output logic [CNT_W-1:0]  bubble_cnt,
  output logic [CNT_W-1:0]  flush_cnt
`endif
);

  if (CNT_W < 1) begin : g_bad_cnt_w
    $error("pipe_stage_buf: CNT_W must be at least 1");
  end

  typedef enum logic [1:0] {
    S_EMPTY = 2'd0,
    S_ONE   = 2'd1,
    S_TWO   = 2'd2
  } state_t;

  state_t state, state_nxt;

  logic [DATA_W-1:0] main_data, skid_data;
  logic [CTRL_W-1:0] main_ctrl, skid_ctrl;

  logic fire_in, fire_out;
  logic load_main_in, load_main_skid, load_skid_in;

  assign fire_in  = in_valid & in_ready;
  assign fire_out = out_valid & out_ready;

  always_ff @(posedge clk) begin
    if (!reset) begin
      state <= S_EMPTY;
    end else begin
      state <= state_nxt;
    end
  end

  // A flush squashes everything, including an entry handshaken this cycle.
  always_comb begin
    state_nxt      = state;
    load_main_in   = 1'b0;
    load_main_skid = 1'b0;
    load_skid_in   = 1'b0;
    if (flush) begin
      state_nxt = S_EMPTY;
    end else begin
      case (state)
        S_EMPTY: begin
          if (fire_in) begin
            load_main_in = 1'b1;
            state_nxt    = S_ONE;
          end
        end
        S_ONE: begin
          if (fire_in && fire_out) begin
            load_main_in = 1'b1;
          end else if (fire_in) begin
            load_skid_in = 1'b1;
            state_nxt    = S_TWO;
          end else if (fire_out) begin
            state_nxt = S_EMPTY;
          end
        end
        S_TWO: begin
          if (fire_out) begin
            load_main_skid = 1'b1;
            state_nxt      = S_ONE;
          end
        end
        default: state_nxt = S_EMPTY;
      endcase
    end
  end

  // in_ready depends on state alone, so upstream never sees out_ready combinationally.
  always_comb begin
    in_ready  = 1'b1;
    out_valid = 1'b0;
    occupancy = 2'd0;
    case (state)
      S_ONE: begin
        out_valid = 1'b1;
        occupancy = 2'd1;
      end
      S_TWO: begin
        in_ready  = 1'b0;
        out_valid = 1'b1;
        occupancy = 2'd2;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      main_data <= '0;
      main_ctrl <= '0;
      skid_data <= '0;
      skid_ctrl <= '0;
    end else begin
      if (load_main_in) begin
        main_data <= in_data;
        main_ctrl <= in_ctrl;
      end else if (load_main_skid) begin
        main_data <= skid_data;
        main_ctrl <= skid_ctrl;
      end
      if (load_skid_in) begin
        skid_data <= in_data;
        skid_ctrl <= in_ctrl;
      end
    end
  end

  // Bubbles carry a zero control word so downstream sees a NOP.
  assign out_data = main_data;
  assign out_ctrl = out_valid ? main_ctrl : '0;

`ifdef PIPE_STAGE_BUF_STATS_EN
  always_ff @(posedge clk) begin
    if (!reset) begin
      stall_cnt  <= '0;
      bubble_cnt <= '0;
      flush_cnt  <= '0;
    end else begin
      if (out_valid && !out_ready && (stall_cnt != '1)) begin
        stall_cnt <= stall_cnt + CNT_W'(1);
      end
      if (!out_valid && (bubble_cnt != '1)) begin
        bubble_cnt <= bubble_cnt + CNT_W'(1);
      end
      if (flush && (flush_cnt != '1)) begin
        flush_cnt <= flush_cnt + CNT_W'(1);
      end
    end
  end
`endif

endmodule

// File: tb/tb_pipe_stage_buf.sv
// tb/tb_pipe_stage_buf.sv - scoreboard bench for pipe_stage_buf against a queue reference model
module tb_pipe_stage_buf;

  localparam int DATA_W = 64;
  localparam int CTRL_W = 16;
`ifdef PIPE_STAGE_BUF_STATS_EN
  localparam int CNT_W = 4;
`else
  localparam int CNT_W = 16;
`endif

  logic              clk = 1'b0;
  logic              reset;
  logic              in_valid;
  logic [DATA_W-1:0] in_data;
  logic [CTRL_W-1:0] in_ctrl;
  logic              in_ready;
  logic              flush;
  logic              out_valid;
  logic [DATA_W-1:0] out_data;
  logic [CTRL_W-1:0] out_ctrl;
  logic              out_ready;
  logic [1:0]        occupancy;
`ifdef PIPE_STAGE_BUF_STATS_EN
  logic [CNT_W-1:0]  stall_cnt, bubble_cnt, flush_cnt;
  int s_stall = 0, s_bubble = 0, s_flush = 0;
  localparam int CNT_MAX = (1 << CNT_W) - 1;
`endif

  always #5 clk = ~clk;

  pipe_stage_buf #(.DATA_W(DATA_W), .CTRL_W(CTRL_W), .CNT_W(CNT_W)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ctrl   (in_ctrl),
    .in_ready  (in_ready),
    .flush     (flush),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_ctrl  (out_ctrl),
    .out_ready (out_ready),
    .occupancy (occupancy)
`ifdef PIPE_STAGE_BUF_STATS_EN
    ,
    .stall_cnt (stall_cnt),
    .bubble_cnt(bubble_cnt),
    .flush_cnt (flush_cnt)
`endif
  );

  typedef struct {
    logic [DATA_W-1:0] d;
    logic [CTRL_W-1:0] c;
  } ent_t;

  ent_t sb[$];
  int   errors = 0;
  int   checks = 0;
  bit   started = 0;
  bit   rst_edge = 0;
  bit   acc = 0;
  bit   mon_popped = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: the buffer is a FIFO of at most two accepted entries.
  initial begin
    forever begin
      @(posedge clk);
      begin
        int n_pre;
        n_pre = sb.size() + (mon_popped ? 1 : 0);
        mon_popped = 0;
        started = 1;
        acc = in_valid && (n_pre < 2);
`ifdef PIPE_STAGE_BUF_STATS_EN
        if (!reset) begin
          s_stall = 0; s_bubble = 0; s_flush = 0;
        end else begin
          if (n_pre > 0 && !out_ready && s_stall < CNT_MAX) s_stall++;
          if (n_pre == 0 && s_bubble < CNT_MAX) s_bubble++;
          if (flush && s_flush < CNT_MAX) s_flush++;
        end
`endif
        if (!reset) begin
          sb.delete();
          rst_edge = 1;
        end else begin
          rst_edge = 0;
          if (flush) sb.delete();
          else if (acc) sb.push_back('{in_data, in_ctrl});
        end
      end
    end
  end

  // Monitor: checks presented outputs and pops the head when downstream consumes it.
  initial begin
    forever begin
      @(negedge clk);
      if (started) begin
        int n;
        n = sb.size();
        chk("occupancy", 64'(occupancy), 64'(n));
        chk("in_ready", 64'(in_ready), 64'(n < 2));
        chk("out_valid", 64'(out_valid), 64'(n > 0));
        if (n > 0) begin
          chk("out_data", out_data, sb[0].d);
          chk("out_ctrl", 64'(out_ctrl), 64'(sb[0].c));
          if (out_ready) begin
            void'(sb.pop_front());
            mon_popped = 1;
          end
        end else begin
          chk("out_ctrl_nop", 64'(out_ctrl), 64'd0);
        end
        if (rst_edge) chk("out_data_reset", out_data, 64'd0);
`ifdef PIPE_STAGE_BUF_STATS_EN
        chk("stall_cnt", 64'(stall_cnt), 64'(s_stall));
        chk("bubble_cnt", 64'(bubble_cnt), 64'(s_bubble));
        chk("flush_cnt", 64'(flush_cnt), 64'(s_flush));
`endif
      end
    end
  end

  task automatic drive(input bit r, input bit v, input logic [DATA_W-1:0] d,
                       input logic [CTRL_W-1:0] c, input bit ordy, input bit fl);
    reset = r; in_valid = v; in_data = d; in_ctrl = c; out_ready = ordy; flush = fl;
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [DATA_W-1:0] d, input logic [CTRL_W-1:0] c, input bit ordy);
    for (int k = 0; k < 20; k++) begin
      drive(1'b1, 1'b1, d, c, ordy, 1'b0);
      if (acc) return;
    end
    chk("send_timeout", 64'd1, 64'd0);
  endtask

  initial begin
    logic [DATA_W-1:0] pd;
    logic [CTRL_W-1:0] pc;
    bit pv;
    pv = 0; pd = '0; pc = '0;

    // Reset with an entry offered, then release
    drive(1'b0, 1'b1, 64'h1234, 16'h00AB, 1'b1, 1'b0);
    drive(1'b0, 1'b1, 64'h1234, 16'h00AB, 1'b1, 1'b0);
    drive(1'b1, 1'b1, 64'h1234, 16'h00AB, 1'b1, 1'b0);
    drive(1'b1, 1'b0, 64'h0, 16'h0, 1'b1, 1'b0);
    drive(1'b1, 1'b0, 64'h0, 16'h0, 1'b1, 1'b0);

    // Streaming
    for (int i = 0; i < 8; i++) drive(1'b1, 1'b1, 64'(i), 16'(i + 1), 1'b1, 1'b0);
    drive(1'b1, 1'b0, 64'h0, 16'h0, 1'b1, 1'b0);

    // Skid: fill, offer a third entry that must wait, then drain in order
    send(64'hAAAA, 16'h0011, 1'b0);
    send(64'hBBBB, 16'h0022, 1'b0);
    drive(1'b1, 1'b1, 64'hCCCC, 16'h0033, 1'b0, 1'b0);
    drive(1'b1, 1'b1, 64'hCCCC, 16'h0033, 1'b0, 1'b0);
    send(64'hCCCC, 16'h0033, 1'b1);
    for (int i = 0; i < 3; i++) drive(1'b1, 1'b0, 64'h0, 16'h0, 1'b1, 1'b0);

    // Flush while full, and flush with a same-cycle handshake
    send(64'h1, 16'h0101, 1'b0);
    send(64'h2, 16'h0202, 1'b0);
    drive(1'b1, 1'b1, 64'hDEAD, 16'h0077, 1'b0, 1'b1);
    drive(1'b1, 1'b0, 64'h0, 16'h0, 1'b1, 1'b0);
    send(64'h3, 16'h0303, 1'b0);
    drive(1'b1, 1'b1, 64'hDEAD, 16'h0077, 1'b1, 1'b1);
    drive(1'b1, 1'b0, 64'h0, 16'h0, 1'b1, 1'b0);

    // Reset together with flush while full
    send(64'h4, 16'h0404, 1'b0);
    send(64'h5, 16'h0505, 1'b0);
    drive(1'b0, 1'b0, 64'h0, 16'h0, 1'b0, 1'b1);
    send(64'h5555, 16'h0555, 1'b1);
    drive(1'b1, 1'b0, 64'h0, 16'h0, 1'b1, 1'b0);
    drive(1'b1, 1'b0, 64'h0, 16'h0, 1'b1, 1'b0);

    // Long stall (saturates narrow counters), flushes and idle cycles
    send(64'h6, 16'h0606, 1'b0);
    for (int i = 0; i < 20; i++) drive(1'b1, 1'b0, 64'h0, 16'h0, 1'b0, 1'b0);
    drive(1'b1, 1'b0, 64'h0, 16'h0, 1'b0, 1'b1);
    drive(1'b1, 1'b0, 64'h0, 16'h0, 1'b0, 1'b1);
    for (int i = 0; i < 4; i++) drive(1'b1, 1'b0, 64'h0, 16'h0, 1'b1, 1'b0);

    // Random traffic; upstream holds an offered entry until accepted
    for (int i = 0; i < 1500; i++) begin
      if (!pv) begin
        pv = ($urandom_range(0, 9) < 7);
        pd = {$urandom, $urandom};
        pc = 16'($urandom);
      end
      drive(($urandom_range(0, 199) != 0), pv, pd, pc,
            ($urandom_range(0, 9) < 6), ($urandom_range(0, 49) == 0));
      if (acc) pv = 0;
    end

    for (int i = 0; i < 4; i++) drive(1'b1, 1'b0, 64'h0, 16'h0, 1'b1, 1'b0);
    chk("drained", 64'(sb.size()), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
